// File: rtl/superh16_int_mul_pipe.sv
`default_nettype none

// ============================================================================
// superh16_pkg
//   Shared execute-cluster types: physical tag / ROB index widths and the
//   micro-op opcode encoding used on the integer issue ports.
// ----------------------------------------------------------------------------
// Revision: 1.0 - initial release
// ============================================================================
package superh16_pkg;

    localparam int PHYS_REG_BITS = 7;
    localparam int ROB_IDX_BITS  = 6;

    typedef enum logic [3:0] {
        UOP_NOP    = 4'd0,
        UOP_ADD    = 4'd1,
        UOP_MUL    = 4'd2,
        UOP_MULH   = 4'd3,
        UOP_MULHU  = 4'd4,
        UOP_MULHSU = 4'd5,
        UOP_MULW   = 4'd6
    } uop_opcode_t;

endpackage

// ============================================================================
// superh16_int_mul_pipe
//   Stallable, flushable integer multiplier with XLEN-wide operands and a
//   LATENCY-stage pipeline. Stage 1 holds opcode-extended operands, stage 2
//   holds the full product, later stages delay it; the result slice is
//   selected combinationally from the last stage.
//
// Ports:
//   clk, rst_n          core clock, asynchronous active-low reset
//   in_valid/in_ready   issue handshake (in_ready = advance && !flush)
//   opcode,src1,src2    micro-op and operands
//   dst_tag, rob_idx    tags carried alongside the op
//   flush               kill every in-flight op, block same-cycle accept
//   result_valid/ready  writeback handshake
//   result, result_dst_tag, result_rob_idx   current result and its tags
//   busy                any stage holds a valid op
// ----------------------------------------------------------------------------
// Revision: 1.0 - initial release
// ============================================================================
module superh16_int_mul_pipe #(
    parameter int XLEN          = 64,
    parameter int LATENCY       = 3,
    parameter int PHYS_REG_BITS = superh16_pkg::PHYS_REG_BITS,
    parameter int ROB_IDX_BITS  = superh16_pkg::ROB_IDX_BITS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  superh16_pkg::uop_opcode_t opcode,
    input  logic [XLEN-1:0]           src1,
    input  logic [XLEN-1:0]           src2,
    input  logic [PHYS_REG_BITS-1:0]  dst_tag,
    input  logic [ROB_IDX_BITS-1:0]   rob_idx,
    input  logic                      flush,
    output logic                      result_valid,
    input  logic                      result_ready,
    output logic [XLEN-1:0]           result,
    output logic [PHYS_REG_BITS-1:0]  result_dst_tag,
    output logic [ROB_IDX_BITS-1:0]   result_rob_idx,
    output logic                      busy
);

    import superh16_pkg::*;

    localparam int c_EW = XLEN + 1;   // extended operand width
    localparam int c_PW = 2 * XLEN;   // kept product width

    logic                      w_advance;
    logic                      w_accept;
    logic [c_EW-1:0]           w_a_ext;
    logic [c_EW-1:0]           w_b_ext;
    logic signed [c_PW-1:0]    w_a_wide;
    logic signed [c_PW-1:0]    w_b_wide;
    logic [c_PW-1:0]           w_prod;
    logic [c_PW-1:0]           w_final;

    logic [LATENCY-1:0]        r_valid;
    logic [c_EW-1:0]           r_a;
    logic [c_EW-1:0]           r_b;
    logic [c_PW-1:0]           r_prod [1:LATENCY-1];
    uop_opcode_t               r_op   [LATENCY];
    logic [PHYS_REG_BITS-1:0]  r_tag  [LATENCY];
    logic [ROB_IDX_BITS-1:0]   r_rob  [LATENCY];

    // A held result freezes every stage, bubbles included.
    assign w_advance = !result_valid || result_ready;
    assign in_ready  = w_advance && !flush;
    assign w_accept  = in_valid && in_ready;

    // Extend both operands by one bit so that a single signed multiplier
    // covers signed, unsigned and mixed-sign forms.
    always_comb begin
        w_a_ext = '0;
        w_b_ext = '0;
        case (opcode)
            UOP_MUL, UOP_MULH: begin
                w_a_ext = {src1[XLEN-1], src1};
                w_b_ext = {src2[XLEN-1], src2};
            end
            UOP_MULHU: begin
                w_a_ext = {1'b0, src1};
                w_b_ext = {1'b0, src2};
            end
            UOP_MULHSU: begin
                w_a_ext = {src1[XLEN-1], src1};
                w_b_ext = {1'b0, src2};
            end
            UOP_MULW: begin
                w_a_ext = {{(c_EW-32){src1[31]}}, src1[31:0]};
                w_b_ext = {{(c_EW-32){src2[31]}}, src2[31:0]};
            end
            default: begin
                w_a_ext = '0;
                w_b_ext = '0;
            end
        endcase
    end

    // Sign-extend to the kept width first: the low 2*XLEN bits of a
    // modulo-2^(2*XLEN) product equal those of the exact signed product.
    assign w_a_wide = c_PW'($signed(r_a));
    assign w_b_wide = c_PW'($signed(r_b));
    assign w_prod   = w_a_wide * w_b_wide;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else if (w_advance) begin
            r_valid <= {r_valid[LATENCY-2:0], w_accept};
        end
    end

    // Payload registers carry no reset; only the valid bits are qualified.
    always_ff @(posedge clk) begin
        if (w_advance) begin
            r_a       <= w_a_ext;
            r_b       <= w_b_ext;
            r_op[0]   <= opcode;
            r_tag[0]  <= dst_tag;
            r_rob[0]  <= rob_idx;
            r_prod[1] <= w_prod;
            for (int i = 1; i < LATENCY; i++) begin
                r_op[i]  <= r_op[i-1];
                r_tag[i] <= r_tag[i-1];
                r_rob[i] <= r_rob[i-1];
            end
            for (int i = 2; i < LATENCY; i++) begin
                r_prod[i] <= r_prod[i-1];
            end
        end
    end

    assign w_final = r_prod[LATENCY-1];

    always_comb begin
        result = '0;
        case (r_op[LATENCY-1])
            UOP_MUL:                        result = w_final[XLEN-1:0];
            UOP_MULH, UOP_MULHU, UOP_MULHSU: result = w_final[c_PW-1:XLEN];
            UOP_MULW:                       result = XLEN'($signed(w_final[31:0]));
            default:                        result = '0;
        endcase
    end

    assign result_valid   = r_valid[LATENCY-1];
    assign result_dst_tag = r_tag[LATENCY-1];
    assign result_rob_idx = r_rob[LATENCY-1];
    assign busy           = |r_valid;

endmodule

`default_nettype wire

// File: doc/superh16_int_mul_pipe.md
Name: superh16_int_mul_pipe

Overview:
Parametrised, stallable, flushable integer multiplier for the SuperH16 execute cluster. It replaces the fixed 3-stage multiplier and adds configurable XLEN and latency, RV64 word-mode multiply (UOP_MULW), valid/ready backpressure and a pipeline flush. It sits on an integer issue port and drives one writeback/wakeup channel.

Parameters:
XLEN, 64, operand/result width; legal values 32 or 64. UOP_MULW is only legal when XLEN=64.
LATENCY, 3, number of register stages from accept to result; legal range 2..6.
PHYS_REG_BITS, superh16_pkg value, physical destination tag width.
ROB_IDX_BITS, superh16_pkg value, ROB index width.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  issue request
in_ready  out  1  multiplier can accept this cycle
opcode  in  uop_opcode_t  UOP_MUL/MULH/MULHU/MULHSU/MULW
src1  in  XLEN  multiplicand
src2  in  XLEN  multiplier
dst_tag  in  PHYS_REG_BITS  destination physical register
rob_idx  in  ROB_IDX_BITS  ROB entry
flush  in  1  kill every in-flight op
result_valid  out  1  result available
result_ready  in  1  writeback accepts result
result  out  XLEN  product slice
result_dst_tag  out  PHYS_REG_BITS  tag of the current result
result_rob_idx  out  ROB_IDX_BITS  ROB index of the current result
busy  out  1  any stage holds a valid op

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: every stage valid bit clears to 0. Outputs: result_valid=0, busy=0, in_ready=1. Data and tag registers are not reset.
- Pipeline: LATENCY stages, each with its own valid bit. advance = !result_valid || result_ready. When advance=0, every stage holds its contents.
- Handshake:
  - in_ready = advance && !flush.
  - An op is accepted on a rising edge where in_valid && in_ready.
  - With no stall, result_valid rises combinationally after the LATENCY-th rising edge following the accept edge.
  - A back-to-back stream gives 1 result per cycle.
- Output hold: result, result_dst_tag and result_rob_idx stay stable while result_valid && !result_ready.
- Bubbles: bubbles do not collapse. A stall freezes the whole pipe.
- Flush:
  - On a flush edge, all stage valid bits clear, so result_valid=0 on the next cycle.
  - An input presented in the same cycle as flush is not accepted.
  - flush overrides a stall.
- Arithmetic: form a (2*XLEN)-bit product from (XLEN+1)-bit extended operands.
  - MUL and MULH: signed × signed.
  - MULHU: unsigned × unsigned.
  - MULHSU: signed src1 × unsigned src2.
  - MULW: src1[31:0] × src2[31:0], signed.
- Result select:
  - MUL: product[XLEN-1:0].
  - MULH, MULHU, MULHSU: product[2XLEN-1:XLEN].
  - MULW: product[31:0] sign-extended to 64 bits.
  - Any other opcode: accepted, produces result=0 with normal latency and tags.
- Opcode-dependent operand extension is done in stage 1. The multiply may be split across stages 1..LATENCY-1. The result mux is combinational on the final stage.
- busy = OR of all stage valid bits.
- Mid-operation reset: all valid bits clear immediately on the rst_n assertion edge, with no outputs glitching high afterwards.

Test Plan:
- MUL src1=3, src2=5, result_ready=1, LATENCY=3 -> result_valid exactly 3 edges later, result=15, tag/rob_idx echoed.
- MULH(-1,-1)=0. MULHU(all-ones,all-ones)=0xFFFF_FFFF_FFFF_FFFE. MULHSU(-1, all-ones)=0xFFFF_FFFF_FFFF_FFFF. MULW(0x7FFF_FFFF, 2)=0xFFFF_FFFF_FFFF_FFFE.
- Issue 4 back-to-back ops, hold result_ready=0 for 5 cycles after the first result -> in_ready=0 throughout the stall, first result held stable, all 4 results emerge in order with none lost or duplicated.
- Assert flush with 3 ops in flight plus in_valid=1 in the same cycle -> no result_valid for those ops, busy=0 next cycle, the same-cycle input is not accepted.
- Assert rst_n low mid-stream -> result_valid=0 and busy=0 immediately. After release, a new MUL 7×6 returns 42 at nominal latency.
- Rebuild with XLEN=32, LATENCY=5 -> MULHU(0xFFFF_FFFF, 0xFFFF_FFFF)=0xFFFF_FFFE after 5 edges. Sustained 1/cycle throughput.
